// File: rtl/boolean_truth_table_scanner_pkg.sv
// Shared widths, types and FSM encoding for the truth-table scanner.
package boolean_scan_pkg;

  localparam int N_IN  = 4;
  localparam int TT_W  = 2 ** N_IN;
  localparam int IDX_W = N_IN;
  localparam int CNT_W = N_IN + 1;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [TT_W-1:0]  tt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/boolean_truth_table_scanner_if.sv
// Scanner bus: control, stimulus/response to the functions under test, results.
// master = controller/function side, slave = scanner.
interface boolean_truth_table_scanner_if
  import boolean_scan_pkg::*;
();

  logic start;
  logic busy;
  logic done;
  idx_t stim_f1;
  idx_t stim_f2;
  logic resp_f1;
  logic resp_f2;
  tt_t  exp_f1;
  tt_t  exp_f2;
  tt_t  tt_f1;
  tt_t  tt_f2;
  cnt_t ones_f1;
  cnt_t ones_f2;
  logic pass;

  modport master (
    output start, resp_f1, resp_f2, exp_f1, exp_f2,
    input  busy, done, stim_f1, stim_f2, tt_f1, tt_f2, ones_f1, ones_f2, pass
  );

  modport slave (
    input  start, resp_f1, resp_f2, exp_f1, exp_f2,
    output busy, done, stim_f1, stim_f2, tt_f1, tt_f2, ones_f1, ones_f2, pass
  );

endinterface

// File: rtl/boolean_truth_table_scanner_tt_capture_lane.sv
// One function lane: truth-table capture by index, minterm count, compare vs expected.
// Capture is one bit per cycle; no backpressure, the FSM paces capture_i.
module tt_capture_lane
  import boolean_scan_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic capture_i,
  input  idx_t idx_i,
  input  logic resp_i,
  input  tt_t  exp_i,
  output tt_t  tt_o,
  output cnt_t ones_o,
  output logic match_o
);

  tt_t  tt_q, tt_d;
  cnt_t ones_q, ones_d;

  always_comb begin
    tt_d   = tt_q;
    ones_d = ones_q;
    if (clear_i) begin
      tt_d   = '0;
      ones_d = '0;
    end else if (capture_i) begin
      tt_d[idx_i] = resp_i;
      ones_d      = ones_q + cnt_t'(resp_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tt_q   <= '0;
      ones_q <= '0;
    end else begin
      tt_q   <= tt_d;
      ones_q <= ones_d;
    end
  end

  assign tt_o    = tt_q;
  assign ones_o  = ones_q;
  assign match_o = (tt_q == exp_i);

endmodule

// File: rtl/boolean_truth_table_scanner.sv
// Scans all 16 input codes into two functions in parallel, 18 cycles start-to-start;
// start is ignored while busy (no queueing), results hold until the next accepted start.
module boolean_truth_table_scanner
  import boolean_scan_pkg::*;
(
  input logic                          clk,
  input logic                          rst,
  boolean_truth_table_scanner_if.slave bus
);

  state_e state_q;
  idx_t   idx_q, idx_d;
  logic   busy_q, done_q, pass_q;
  logic   clear, capture;
  logic   match_f1, match_f2;

  assign idx_d   = idx_q + idx_t'(1);
  assign clear   = (state_q == IDLE) && bus.start;
  assign capture = (state_q == SCAN);

  // idx wraps back to 0 on the last SCAN edge, so IDLE drives stim = 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= SCAN;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            pass_q  <= 1'b0;
          end
        end
        SCAN: begin
          idx_q <= idx_d;
          if (idx_q == idx_t'(TT_W - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          pass_q  <= match_f1 && match_f2;
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  tt_capture_lane u_lane_f1 (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (clear),
    .capture_i (capture),
    .idx_i     (idx_q),
    .resp_i    (bus.resp_f1),
    .exp_i     (bus.exp_f1),
    .tt_o      (bus.tt_f1),
    .ones_o    (bus.ones_f1),
    .match_o   (match_f1)
  );

  tt_capture_lane u_lane_f2 (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (clear),
    .capture_i (capture),
    .idx_i     (idx_q),
    .resp_i    (bus.resp_f2),
    .exp_i     (bus.exp_f2),
    .tt_o      (bus.tt_f2),
    .ones_o    (bus.ones_f2),
    .match_o   (match_f2)
  );

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
  assign bus.stim_f1 = idx_q;
  assign bus.stim_f2 = idx_q;

endmodule

// File: tb/tb_boolean_truth_table_scanner.sv
// Directed bench: golden minimised functions, constants, mismatch, start-while-busy, reset mid-scan.
module tb_boolean_truth_table_scanner;

  logic clk;
  logic rst;
  int   mode;
  int   vec_cnt;
  int   err_cnt;

  boolean_truth_table_scanner_if bif ();

  boolean_truth_table_scanner dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic f1_model(input logic [3:0] s);
    logic a, b, c, d;
    {a, b, c, d} = s;
    return (!a && !b && !c && !d) || (a && !c && !d) || (!b && c && !d) ||
           (!a && b && c && d) || (b && !c && d);
  endfunction

  function automatic logic f2_model(input logic [3:0] s);
    logic w, x, y, z;
    {w, x, y, z} = s;
    return (x && !y && z) || (!x && !y && z) || (!w && x && y) ||
           (w && !x && y) || (w && x && y);
  endfunction

  always_comb begin
    if (mode == 0) begin
      bif.resp_f1 = f1_model(bif.stim_f1);
      bif.resp_f2 = f2_model(bif.stim_f2);
    end else begin
      bif.resp_f1 = 1'b0;
      bif.resp_f2 = 1'b1;
    end
  end

  // Issues start at a negedge; returns cycle index (1 = first after the accepting edge) of done.
  task automatic do_scan(output int done_cyc);
    bif.start = 1'b1;
    @(posedge clk);
    #1 bif.start = 1'b0;
    done_cyc = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bif.done) begin
        done_cyc = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vec_cnt++; if (bif.busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %b want 0", bif.busy); end
    vec_cnt++; if (bif.done !== 1'b0) begin err_cnt++; $display("FAIL reset_done got %b want 0", bif.done); end
    vec_cnt++; if (bif.pass !== 1'b0) begin err_cnt++; $display("FAIL reset_pass got %b want 0", bif.pass); end
    vec_cnt++; if (bif.stim_f1 !== 4'h0) begin err_cnt++; $display("FAIL reset_stim_f1 got %h want 0", bif.stim_f1); end
    vec_cnt++; if (bif.stim_f2 !== 4'h0) begin err_cnt++; $display("FAIL reset_stim_f2 got %h want 0", bif.stim_f2); end
    vec_cnt++; if (bif.tt_f1 !== 16'h0000) begin err_cnt++; $display("FAIL reset_tt_f1 got %h want 0000", bif.tt_f1); end
    vec_cnt++; if (bif.tt_f2 !== 16'h0000) begin err_cnt++; $display("FAIL reset_tt_f2 got %h want 0000", bif.tt_f2); end
    vec_cnt++; if (bif.ones_f1 !== 5'd0) begin err_cnt++; $display("FAIL reset_ones_f1 got %0d want 0", bif.ones_f1); end
    vec_cnt++; if (bif.ones_f2 !== 5'd0) begin err_cnt++; $display("FAIL reset_ones_f2 got %0d want 0", bif.ones_f2); end
  endtask

  task automatic test_golden;
    int dc;
    mode = 0;
    bif.exp_f1 = 16'h35A5;
    bif.exp_f2 = 16'hEEE2;
    do_scan(dc);
    vec_cnt++; if (dc !== 17) begin err_cnt++; $display("FAIL golden_done_cycle got %0d want 17", dc); end
    vec_cnt++; if (bif.busy !== 1'b1) begin err_cnt++; $display("FAIL golden_busy_in_done got %b want 1", bif.busy); end
    vec_cnt++; if (bif.tt_f1 !== 16'h35A5) begin err_cnt++; $display("FAIL golden_tt_f1 got %h want 35a5", bif.tt_f1); end
    vec_cnt++; if (bif.ones_f1 !== 5'd8) begin err_cnt++; $display("FAIL golden_ones_f1 got %0d want 8", bif.ones_f1); end
    vec_cnt++; if (bif.tt_f2 !== 16'hEEE2) begin err_cnt++; $display("FAIL golden_tt_f2 got %h want eee2", bif.tt_f2); end
    vec_cnt++; if (bif.ones_f2 !== 5'd10) begin err_cnt++; $display("FAIL golden_ones_f2 got %0d want 10", bif.ones_f2); end
    @(negedge clk);
    vec_cnt++; if (bif.pass !== 1'b1) begin err_cnt++; $display("FAIL golden_pass got %b want 1", bif.pass); end
    vec_cnt++; if (bif.busy !== 1'b0) begin err_cnt++; $display("FAIL golden_busy_after got %b want 0", bif.busy); end
    vec_cnt++; if (bif.stim_f1 !== 4'h0) begin err_cnt++; $display("FAIL golden_stim_idle got %h want 0", bif.stim_f1); end
  endtask

  task automatic test_constants;
    int dc;
    mode = 1;
    bif.exp_f1 = 16'h0000;
    bif.exp_f2 = 16'hFFFF;
    do_scan(dc);
    vec_cnt++; if (dc !== 17) begin err_cnt++; $display("FAIL const_done_cycle got %0d want 17", dc); end
    vec_cnt++; if (bif.tt_f1 !== 16'h0000) begin err_cnt++; $display("FAIL const_tt_f1 got %h want 0000", bif.tt_f1); end
    vec_cnt++; if (bif.ones_f1 !== 5'd0) begin err_cnt++; $display("FAIL const_ones_f1 got %0d want 0", bif.ones_f1); end
    vec_cnt++; if (bif.tt_f2 !== 16'hFFFF) begin err_cnt++; $display("FAIL const_tt_f2 got %h want ffff", bif.tt_f2); end
    vec_cnt++; if (bif.ones_f2 !== 5'd16) begin err_cnt++; $display("FAIL const_ones_f2 got %0d want 16", bif.ones_f2); end
    @(negedge clk);
    vec_cnt++; if (bif.pass !== 1'b1) begin err_cnt++; $display("FAIL const_pass got %b want 1", bif.pass); end
  endtask

  task automatic test_mismatch;
    int dc;
    mode = 0;
    bif.exp_f1 = 16'h35A4;
    bif.exp_f2 = 16'hEEE2;
    do_scan(dc);
    vec_cnt++; if (bif.tt_f1 !== 16'h35A5) begin err_cnt++; $display("FAIL mism_tt_f1 got %h want 35a5", bif.tt_f1); end
    vec_cnt++; if (bif.pass !== 1'b0) begin err_cnt++; $display("FAIL mism_pass_cleared got %b want 0", bif.pass); end
    @(negedge clk);
    vec_cnt++; if (bif.pass !== 1'b0) begin err_cnt++; $display("FAIL mism_pass got %b want 0", bif.pass); end
  endtask

  task automatic test_start_while_busy;
    int ndone;
    int dc;
    int busy_after;
    mode = 0;
    bif.exp_f1 = 16'h35A5;
    bif.exp_f2 = 16'hEEE2;
    ndone = 0;
    dc = -1;
    busy_after = 0;
    bif.start = 1'b1;
    @(posedge clk);
    #1 bif.start = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      bif.start = 1'b0;
      if (n == 1) begin
        vec_cnt++;
        if (bif.busy !== 1'b1 || bif.stim_f1 !== 4'h0) begin
          err_cnt++; $display("FAIL busy_first_cycle got busy=%b stim=%h want busy=1 stim=0", bif.busy, bif.stim_f1);
        end
      end
      if (bif.busy && bif.stim_f1 == 4'h5) bif.start = 1'b1;
      if (bif.done) begin
        ndone++;
        dc = n;
        bif.start = 1'b1;
      end
      if (n >= 18 && bif.busy) busy_after++;
    end
    bif.start = 1'b0;
    vec_cnt++; if (ndone !== 1) begin err_cnt++; $display("FAIL busy_done_count got %0d want 1", ndone); end
    vec_cnt++; if (dc !== 17) begin err_cnt++; $display("FAIL busy_done_cycle got %0d want 17", dc); end
    vec_cnt++; if (busy_after !== 0) begin err_cnt++; $display("FAIL busy_no_requeue got %0d busy cycles want 0", busy_after); end
    vec_cnt++; if (bif.tt_f1 !== 16'h35A5 || bif.tt_f2 !== 16'hEEE2) begin
      err_cnt++; $display("FAIL busy_tables got %h/%h want 35a5/eee2", bif.tt_f1, bif.tt_f2);
    end
    vec_cnt++; if (bif.pass !== 1'b1) begin err_cnt++; $display("FAIL busy_pass got %b want 1", bif.pass); end
  endtask

  task automatic test_reset_mid_scan;
    int found;
    int ndone;
    int dc;
    mode = 0;
    bif.exp_f1 = 16'h35A5;
    bif.exp_f2 = 16'hEEE2;
    found = 0;
    ndone = 0;
    bif.start = 1'b1;
    @(posedge clk);
    #1 bif.start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bif.busy && bif.stim_f1 == 4'h7) begin
        found = 1;
        break;
      end
    end
    vec_cnt++; if (found !== 1) begin err_cnt++; $display("FAIL rstmid_reach_idx7 got %0d want 1", found); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vec_cnt++; if (bif.busy !== 1'b0) begin err_cnt++; $display("FAIL rstmid_busy got %b want 0", bif.busy); end
    vec_cnt++; if (bif.tt_f1 !== 16'h0000 || bif.tt_f2 !== 16'h0000) begin
      err_cnt++; $display("FAIL rstmid_tables got %h/%h want 0000/0000", bif.tt_f1, bif.tt_f2);
    end
    vec_cnt++; if (bif.ones_f1 !== 5'd0 || bif.ones_f2 !== 5'd0) begin
      err_cnt++; $display("FAIL rstmid_ones got %0d/%0d want 0/0", bif.ones_f1, bif.ones_f2);
    end
    vec_cnt++; if (bif.stim_f1 !== 4'h0) begin err_cnt++; $display("FAIL rstmid_stim got %h want 0", bif.stim_f1); end
    for (int n = 0; n < 20; n++) begin
      if (bif.done) ndone++;
      @(negedge clk);
    end
    vec_cnt++; if (ndone !== 0) begin err_cnt++; $display("FAIL rstmid_no_done got %0d want 0", ndone); end
    do_scan(dc);
    vec_cnt++; if (dc !== 17) begin err_cnt++; $display("FAIL rstmid_rescan_cycle got %0d want 17", dc); end
    vec_cnt++; if (bif.tt_f1 !== 16'h35A5 || bif.ones_f1 !== 5'd8) begin
      err_cnt++; $display("FAIL rstmid_rescan_f1 got %h/%0d want 35a5/8", bif.tt_f1, bif.ones_f1);
    end
    vec_cnt++; if (bif.tt_f2 !== 16'hEEE2 || bif.ones_f2 !== 5'd10) begin
      err_cnt++; $display("FAIL rstmid_rescan_f2 got %h/%0d want eee2/10", bif.tt_f2, bif.ones_f2);
    end
    @(negedge clk);
    vec_cnt++; if (bif.pass !== 1'b1) begin err_cnt++; $display("FAIL rstmid_rescan_pass got %b want 1", bif.pass); end
  endtask

  initial begin
    vec_cnt    = 0;
    err_cnt    = 0;
    mode       = 0;
    rst        = 1'b1;
    bif.start  = 1'b0;
    bif.exp_f1 = '0;
    bif.exp_f2 = '0;
    test_reset();
    test_golden();
    test_constants();
    test_mismatch();
    test_start_while_busy();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
